// File: rtl/ddr3_maint_pkg.sv
// Shared state encoding and default maintenance intervals for the DDR3 maintenance scheduler.
package ddr3_maint_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REF_REQ   = 3'd1,
        ST_ZQ_REQ    = 3'd2,
        ST_SR_ENTER  = 3'd3,
        ST_SR_ACTIVE = 3'd4,
        ST_SR_EXIT   = 3'd5
    } state_t;

    localparam int unsigned REFI_CYCLES_DEF = 1560;
    localparam int unsigned ZQ_CYCLES_DEF   = 25600000;
    localparam int unsigned ACK_TIMEOUT_DEF = 1024;
    localparam int unsigned MAX_PENDING_DEF = 8;

    // Bits needed to hold 0..n-1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ddr3_maint_timer.sv
// Free-running interval timer 0..PERIOD-1; o_tick is combinational so the owner can act on the wrap edge.
module ddr3_maint_timer #(
    parameter int unsigned WIDTH  = 11,
    parameter int unsigned PERIOD = 1560
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_tick
);

    logic [WIDTH-1:0] r_count;
    logic             w_last;

    assign w_last = (r_count == WIDTH'(PERIOD - 1));
    assign o_tick = i_enable && !i_clear && w_last;

    // Clear wins over enable so a restart never reports a stale wrap.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= w_last ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/ddr3_maint_sched.sv
// DDR3 refresh / ZQ / self-refresh scheduler. Define DDR3_MAINT_ZQ_PERIODIC_EN to add the periodic ZQ timer;
// otherwise ZQ calibration is requested only by i_zq_ext_req.
module ddr3_maint_sched
    import ddr3_maint_pkg::*;
#(
    parameter int unsigned REFI_CYCLES = REFI_CYCLES_DEF,
    parameter int unsigned ZQ_CYCLES   = ZQ_CYCLES_DEF,
    parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF,
    parameter int unsigned MAX_PENDING = MAX_PENDING_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_calib_done,
    input  logic       i_sleep_req,
    input  logic       i_zq_ext_req,
    output logic       o_ref_req,
    input  logic       i_ref_ack,
    output logic       o_zq_req,
    input  logic       i_zq_ack,
    output logic       o_sr_req,
    input  logic       i_sr_active,
    output logic [3:0] o_ref_pending,
    output logic       o_sleeping,
    output logic       o_ack_timeout,
    output logic       o_ref_overflow
);

    localparam int unsigned REFI_W = cnt_width(REFI_CYCLES);
    localparam int unsigned WAIT_W = cnt_width(ACK_TIMEOUT);

    if (REFI_CYCLES < 2 || ZQ_CYCLES < 2 || ACK_TIMEOUT < 2 || MAX_PENDING < 1 || MAX_PENDING > 15) begin : g_bad_cfg
        $fatal(1, "ddr3_maint_sched: unsupported parameter set");
    end

    state_t            r_state;
    logic              r_ref_req;
    logic              r_zq_req;
    logic              r_sr_req;
    logic              r_sleeping;
    logic              r_ack_timeout;
    logic              r_ref_overflow;
    logic              r_zq_flag;
    logic [3:0]        r_ref_pending;
    logic [WAIT_W-1:0] r_wait;

    logic w_timer_en;
    logic w_refi_clear;
    logic w_ref_tick;
    logic w_zq_tick;
    logic w_ref_ack;
    logic w_ref_full;
    logic w_wait_expired;

    // Timers freeze while the DRAM refreshes itself; the REFI phase restarts once self-refresh is left.
    assign w_timer_en     = i_calib_done && (r_state != ST_SR_ACTIVE);
    assign w_refi_clear   = !i_calib_done || ((r_state == ST_SR_EXIT) && !i_sr_active);
    assign w_ref_ack      = (r_state == ST_REF_REQ) && i_ref_ack;
    assign w_ref_full     = (r_ref_pending == 4'(MAX_PENDING));
    assign w_wait_expired = (r_wait == WAIT_W'(ACK_TIMEOUT - 1));

    ddr3_maint_timer #(
        .WIDTH  (REFI_W),
        .PERIOD (REFI_CYCLES)
    ) u_refi_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_enable (w_timer_en),
        .i_clear  (w_refi_clear),
        .o_tick   (w_ref_tick)
    );

`ifdef DDR3_MAINT_ZQ_PERIODIC_EN
    ddr3_maint_timer #(
        .WIDTH  (32),
        .PERIOD (ZQ_CYCLES)
    ) u_zq_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_enable (w_timer_en),
        .i_clear  (!i_calib_done),
        .o_tick   (w_zq_tick)
    );
`else
    assign w_zq_tick = 1'b0;
`endif

    // Owed-refresh counter; a wrap coinciding with an ack cancels out.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ref_pending  <= '0;
            r_ref_overflow <= 1'b0;
        end else if (!i_calib_done || (r_state == ST_SR_ACTIVE)) begin
            r_ref_pending <= '0;
        end else if (w_ref_tick && !w_ref_ack) begin
            if (w_ref_full) begin
                r_ref_overflow <= 1'b1;
            end else begin
                r_ref_pending <= r_ref_pending + 4'd1;
            end
        end else if (!w_ref_tick && w_ref_ack && (r_ref_pending != 4'd0)) begin
            r_ref_pending <= r_ref_pending - 4'd1;
        end
    end

    // A new ZQ request arriving with an ack keeps the flag set so it is not lost.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_zq_flag <= 1'b0;
        end else if (!i_calib_done) begin
            r_zq_flag <= 1'b0;
        end else if (i_zq_ext_req || w_zq_tick) begin
            r_zq_flag <= 1'b1;
        end else if ((r_state == ST_ZQ_REQ) && i_zq_ack) begin
            r_zq_flag <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_ref_req     <= 1'b0;
            r_zq_req      <= 1'b0;
            r_sr_req      <= 1'b0;
            r_sleeping    <= 1'b0;
            r_ack_timeout <= 1'b0;
            r_wait        <= '0;
        end else if (!i_calib_done) begin
            r_state    <= ST_IDLE;
            r_ref_req  <= 1'b0;
            r_zq_req   <= 1'b0;
            r_sr_req   <= 1'b0;
            r_sleeping <= 1'b0;
            r_wait     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_wait <= '0;
                    if (r_ref_pending != 4'd0) begin
                        r_state   <= ST_REF_REQ;
                        r_ref_req <= 1'b1;
                    end else if (r_zq_flag) begin
                        r_state  <= ST_ZQ_REQ;
                        r_zq_req <= 1'b1;
                    end else if (i_sleep_req) begin
                        r_state  <= ST_SR_ENTER;
                        r_sr_req <= 1'b1;
                    end
                end
                ST_REF_REQ: begin
                    if (i_ref_ack) begin
                        r_state   <= ST_IDLE;
                        r_ref_req <= 1'b0;
                    end else if (w_wait_expired) begin
                        r_state       <= ST_IDLE;
                        r_ref_req     <= 1'b0;
                        r_ack_timeout <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                ST_ZQ_REQ: begin
                    if (i_zq_ack) begin
                        r_state  <= ST_IDLE;
                        r_zq_req <= 1'b0;
                    end else if (w_wait_expired) begin
                        r_state       <= ST_IDLE;
                        r_zq_req      <= 1'b0;
                        r_ack_timeout <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                ST_SR_ENTER: begin
                    if (i_sr_active) begin
                        r_state    <= ST_SR_ACTIVE;
                        r_sleeping <= 1'b1;
                    end
                end
                ST_SR_ACTIVE: begin
                    if (!i_sleep_req) begin
                        r_state    <= ST_SR_EXIT;
                        r_sr_req   <= 1'b0;
                        r_sleeping <= 1'b0;
                    end
                end
                ST_SR_EXIT: begin
                    if (!i_sr_active) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_ref_req  <= 1'b0;
                    r_zq_req   <= 1'b0;
                    r_sr_req   <= 1'b0;
                    r_sleeping <= 1'b0;
                end
            endcase
        end
    end

    assign o_ref_req      = r_ref_req;
    assign o_zq_req       = r_zq_req;
    assign o_sr_req       = r_sr_req;
    assign o_ref_pending  = r_ref_pending;
    assign o_sleeping     = r_sleeping;
    assign o_ack_timeout  = r_ack_timeout;
    assign o_ref_overflow = r_ref_overflow;

endmodule

// File: tb/tb_ddr3_maint_sched.sv
// Directed bench for ddr3_maint_sched with REFI=16, ZQ=100, ACK_TIMEOUT=8, MAX_PENDING=8.
module tb_ddr3_maint_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       calib_done;
    logic       sleep_req;
    logic       zq_ext_req;
    logic       ref_req;
    logic       ref_ack;
    logic       zq_req;
    logic       zq_ack;
    logic       sr_req;
    logic       sr_active;
    logic [3:0] ref_pending;
    logic       sleeping;
    logic       ack_timeout;
    logic       ref_overflow;

    int n_checks = 0;
    int n_errors = 0;
    int n;

    always #5 clk = ~clk;

    ddr3_maint_sched #(
        .REFI_CYCLES (16),
        .ZQ_CYCLES   (100),
        .ACK_TIMEOUT (8),
        .MAX_PENDING (8)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_calib_done   (calib_done),
        .i_sleep_req    (sleep_req),
        .i_zq_ext_req   (zq_ext_req),
        .o_ref_req      (ref_req),
        .i_ref_ack      (ref_ack),
        .o_zq_req       (zq_req),
        .i_zq_ack       (zq_ack),
        .o_sr_req       (sr_req),
        .i_sr_active    (sr_active),
        .o_ref_pending  (ref_pending),
        .o_sleeping     (sleeping),
        .o_ack_timeout  (ack_timeout),
        .o_ref_overflow (ref_overflow)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        calib_done = 1'b0;
        sleep_req  = 1'b0;
        zq_ext_req = 1'b0;
        ref_ack    = 1'b0;
        zq_ack     = 1'b0;
        sr_active  = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic wait_ref_req(input int budget, output int cycles);
        cycles = 0;
        while (!ref_req && cycles < budget) begin
            tick(1);
            cycles++;
        end
        if (!ref_req) check_val("ref_req_wait", ref_req, 1);
    endtask

    initial begin
        rst        = 1'b1;
        calib_done = 1'b0;
        sleep_req  = 1'b0;
        zq_ext_req = 1'b0;
        ref_ack    = 1'b0;
        zq_ack     = 1'b0;
        sr_active  = 1'b0;
        tick(2);
        check_val("rst_outputs", {ref_req, zq_req, sr_req, sleeping, ack_timeout, ref_overflow}, 0);
        check_val("rst_pending", ref_pending, 0);
        rst = 1'b0;
        tick(20);
        check_val("uncal_pending", ref_pending, 0);
        check_val("uncal_ref_req", ref_req, 0);

        // Periodic refresh with ack two cycles after each request.
        calib_done = 1'b1;
        wait_ref_req(40, n);
        check_val("first_ref_latency", n, 17);
        check_val("first_ref_pending", ref_pending, 1);
        for (int r = 0; r < 3; r++) begin
            tick(2);
            ref_ack = 1'b1;
            tick(1);
            ref_ack = 1'b0;
            check_val("ack_drops_req", ref_req, 0);
            check_val("ack_pending_zero", ref_pending, 0);
            wait_ref_req(40, n);
            check_val("ref_interval", n + 3, 16);
        end

        // Withheld ack: timeout after 8 wait cycles, request re-issued.
        tick(7);
        check_val("to_req_still_high", ref_req, 1);
        check_val("to_not_yet", ack_timeout, 0);
        tick(1);
        check_val("to_req_dropped", ref_req, 0);
        check_val("to_sticky_set", ack_timeout, 1);
        check_val("to_pending_kept", ref_pending, 1);
        tick(1);
        check_val("to_rerequest", ref_req, 1);
        tick(1);
        ref_ack = 1'b1;
        tick(1);
        ref_ack = 1'b0;
        check_val("to_late_ack", ref_pending, 0);

        // No acks: pending saturates at 8, the ninth wrap overflows.
        n = 0;
        while (ref_pending != 4'd8 && n < 200) begin
            tick(1);
            n++;
        end
        check_val("sat_pending", ref_pending, 8);
        check_val("sat_no_overflow", ref_overflow, 0);
        tick(15);
        check_val("sat_overflow_pre", ref_overflow, 0);
        tick(1);
        check_val("sat_overflow", ref_overflow, 1);
        check_val("sat_pending_hold", ref_pending, 8);

        // Self-refresh entry and exit.
        do_reset();
        calib_done = 1'b1;
        sleep_req  = 1'b1;
        tick(1);
        check_val("sr_enter_req", sr_req, 1);
        tick(2);
        sr_active = 1'b1;
        tick(1);
        check_val("sr_sleeping", sleeping, 1);
        tick(20);
        check_val("sr_pending", ref_pending, 0);
        check_val("sr_no_ref", ref_req, 0);
        check_val("sr_req_held", sr_req, 1);
        sleep_req = 1'b0;
        tick(1);
        check_val("sr_exit_req", sr_req, 0);
        check_val("sr_exit_sleeping", sleeping, 0);
        tick(2);
        sr_active = 1'b0;
        tick(1);
        wait_ref_req(40, n);
        check_val("sr_refi_restart", n, 17);

        // External ZQ alongside an owed refresh: refresh first.
        do_reset();
        calib_done = 1'b1;
        n = 0;
        while (ref_pending == 4'd0 && n < 40) begin
            tick(1);
            n++;
        end
        zq_ext_req = 1'b1;
        tick(1);
        zq_ext_req = 1'b0;
        check_val("zq_ref_first", ref_req, 1);
        check_val("zq_waits", zq_req, 0);
        tick(1);
        ref_ack = 1'b1;
        tick(1);
        ref_ack = 1'b0;
        check_val("zq_ref_done", ref_req, 0);
        tick(1);
        check_val("zq_req_up", zq_req, 1);
        zq_ack = 1'b1;
        tick(1);
        zq_ack = 1'b0;
        check_val("zq_req_down", zq_req, 0);
        tick(2);
        check_val("zq_flag_cleared", zq_req, 0);

        // Calibration loss during a refresh request.
        do_reset();
        calib_done = 1'b1;
        wait_ref_req(40, n);
        tick(8);
        check_val("cal_to_set", ack_timeout, 1);
        tick(1);
        calib_done = 1'b0;
        tick(1);
        check_val("cal_drop_req", ref_req, 0);
        check_val("cal_drop_pending", ref_pending, 0);
        check_val("cal_sticky_kept", ack_timeout, 1);

`ifdef DDR3_MAINT_ZQ_PERIODIC_EN
        // Periodic ZQ every 100 cycles with refreshes acked promptly.
        do_reset();
        calib_done = 1'b1;
        n = 0;
        while (!zq_req && n < 130) begin
            ref_ack = ref_req;
            tick(1);
            n++;
        end
        ref_ack = 1'b0;
        check_val("zqp_first", n, 101);
        zq_ack = 1'b1;
        tick(1);
        zq_ack = 1'b0;
        n = 0;
        while (!zq_req && n < 130) begin
            ref_ack = ref_req;
            tick(1);
            n++;
        end
        ref_ack = 1'b0;
        check_val("zqp_second", n, 99);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
